mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data field width.
REQ-002 Parameter ADDR_WIDTH, default 31, address field width.
REQ-003 Parameter TID_WIDTH, default 16, transaction ID width.
REQ-004 Parameter MAX_OUTSTANDING, default 4, scoreboard depth; SHALL be ≤ 2^TID_WIDTH.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Port req_valid / req_ready, input / output, 1 each, host request handshake.
REQ-008 Port req_rw, input, 1, 1 = read, 0 = write.
REQ-009 Port req_addr / req_data, input, ADDR_WIDTH / DATA_WIDTH, request address and write data.
REQ-010 Port write_ctr, output, 1, request-FIFO write enable.
REQ-011 Port outgoing_data, output, TID+1+ADDR+DATA, packed {tid, rw, addr, data}.
REQ-012 Port full_signal, input, 1, request FIFO full.
REQ-013 Port read_ctr, output, 1, response-FIFO read enable.
REQ-014 Port incoming_data, input, TID+DATA, packed {tid, data}, valid the cycle after read_ctr.
REQ-015 Port empty_signal, input, 1, response FIFO empty.
REQ-016 Port resp_valid / resp_ready, output / input, 1 each, host response handshake.
REQ-017 Port resp_tid / resp_rw / resp_data, output, TID_WIDTH / 1 / DATA_WIDTH, returned transaction.
REQ-018 Port outstanding, output, clog2(MAX_OUTSTANDING+1), count of live scoreboard entries.
REQ-019 Port err_unknown_tid, output, 1, one-cycle pulse on unmatched response.

Function
REQ-020 req_ready SHALL be combinational: !full_signal && outstanding < MAX_OUTSTANDING.
REQ-021 Accept = req_valid && req_ready; write_ctr SHALL equal accept in the same cycle, outgoing_data = {next_tid, req_rw, req_addr, req_data}.
REQ-022 next_tid SHALL increment by 1 per accept, modulo 2^TID_WIDTH (wrap from all-ones to 0).
REQ-023 On accept the lowest-index free scoreboard slot SHALL be loaded with {valid=1, tid, rw}.
REQ-024 Response FSM states: IDLE, WAIT_DATA, HOLD.
REQ-025 IDLE: read_ctr = !empty_signal; if asserted, go to WAIT_DATA; read_ctr SHALL be 0 in all other states.
REQ-026 WAIT_DATA: compare incoming_data tid against all valid slots.
REQ-027 On a hit: register resp_tid/resp_rw/resp_data, clear the slot, go to HOLD.
REQ-028 On a miss: pulse err_unknown_tid for one cycle, drop the word, return to IDLE.
REQ-029 HOLD: resp_valid = 1 and outputs stable; on resp_ready go to IDLE.
REQ-030 Same-cycle allocate and free: outstanding unchanged; the freed slot is usable from the next cycle.
REQ-031 Requests at outstanding = MAX_OUTSTANDING SHALL stall (req_ready = 0) until a slot frees.
REQ-032 full_signal and empty_signal are sampled each cycle; no write occurs while full, no read while empty.

Reset
REQ-033 On reset low, asynchronously: scoreboard valid bits 0, next_tid 0, outstanding 0, FSM IDLE.
REQ-034 On reset low, asynchronously: resp_valid 0, resp_tid/resp_rw/resp_data 0, err_unknown_tid 0.
REQ-035 While reset is low, combinational write_ctr and read_ctr SHALL be 0.
REQ-036 Reset mid-transaction SHALL discard all in-flight state; responses arriving afterward report err_unknown_tid.

Structure
REQ-037 Package mem_if_pkg SHALL hold the width parameters, packed-field bit positions, and FSM state encoding, shared with mem_controller.
REQ-038 Sub-module mem_req_scoreboard SHALL hold slot allocation, TID lookup/free, and the outstanding count.

Verification
REQ-039 Reset, then one read to addr 0x10 -> write_ctr for 1 cycle, outgoing_data tid=0, rw=1, addr=0x10; after incoming {0, 0x7}: resp_valid with tid 0, rw 1, data 0x7.
REQ-040 5 back-to-back requests, no responses -> 4 accepted (tids 0-3), req_ready = 0, outstanding = 4; one response frees a slot, 5th accepted with tid 4.
REQ-041 Responses returned in order 2,0,3,1 -> each matched, correct rw returned, outstanding reaches 0.
REQ-042 Incoming tid 0x55 with no live entry -> err_unknown_tid 1-cycle pulse, no resp_valid, outstanding unchanged.
REQ-043 next_tid preset via 65535 issue/response pairs -> next request carries tid 0xFFFF, the following carries 0x0000.
REQ-044 full_signal held 1 -> write_ctr stays 0; resp_ready held 0 in HOLD -> read_ctr stays 0 with FIFO non-empty; reset asserted in HOLD -> resp_valid drops immediately.

Source files
------------

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, packed-field positions and response FSM encoding
package mem_if_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH      = 31;
    localparam int DEF_TID_WIDTH       = 16;
    localparam int DEF_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_HOLD      = 2'd2
    } resp_state_t;

    // Request word is {tid, rw, addr, data}; response word is {tid, data}.
    function automatic int out_addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int out_rw_pos(input int dw, input int aw);
        return dw + aw;
    endfunction

    function automatic int out_tid_lsb(input int dw, input int aw);
        return dw + aw + 1;
    endfunction

    function automatic int in_tid_lsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/mem_requester_if.sv
// rtl/mem_requester_if.sv - host, request-FIFO and response-FIFO signals of mem_requester
interface mem_requester_if #(
    parameter int DATA_WIDTH      = mem_if_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = mem_if_pkg::DEF_ADDR_WIDTH,
    parameter int TID_WIDTH       = mem_if_pkg::DEF_TID_WIDTH,
    parameter int MAX_OUTSTANDING = mem_if_pkg::DEF_MAX_OUTSTANDING
);
    localparam int OUT_W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int IN_W  = TID_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  write_ctr;
    logic [OUT_W-1:0]      outgoing_data;
    logic                  full_signal;
    logic                  read_ctr;
    logic [IN_W-1:0]       incoming_data;
    logic                  empty_signal;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [TID_WIDTH-1:0]  resp_tid;
    logic                  resp_rw;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [CNT_W-1:0]      outstanding;
    logic                  err_unknown_tid;

    modport master (
        input  req_valid, req_rw, req_addr, req_data, full_signal,
               incoming_data, empty_signal, resp_ready,
        output req_ready, write_ctr, outgoing_data, read_ctr,
               resp_valid, resp_tid, resp_rw, resp_data, outstanding, err_unknown_tid
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_data, full_signal,
               incoming_data, empty_signal, resp_ready,
        input  req_ready, write_ctr, outgoing_data, read_ctr,
               resp_valid, resp_tid, resp_rw, resp_data, outstanding, err_unknown_tid
    );

endinterface

// File: rtl/mem_req_scoreboard.sv
// rtl/mem_req_scoreboard.sv - outstanding-transaction slots: allocate, TID lookup/free, live count
module mem_req_scoreboard #(
    parameter int TID_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_alloc,
    input  logic [TID_WIDTH-1:0] i_alloc_tid,
    input  logic                 i_alloc_rw,
    input  logic                 i_lookup_en,
    input  logic [TID_WIDTH-1:0] i_lookup_tid,
    output logic                 o_hit,
    output logic                 o_hit_rw,
    output logic [CNT_W-1:0]     o_outstanding
);
    localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [MAX_OUTSTANDING-1:0] r_valid;
    logic [MAX_OUTSTANDING-1:0] r_rw;
    logic [TID_WIDTH-1:0]       r_tid [MAX_OUTSTANDING];
    logic [CNT_W-1:0]           r_count;

    logic [SLOT_W-1:0] w_alloc_idx;
    logic [SLOT_W-1:0] w_hit_idx;
    logic              w_free_found;
    logic              w_match;
    logic              w_do_alloc;

    // Descending scans so the last assignment wins: lowest-index slot is chosen.
    always_comb begin
        w_alloc_idx  = '0;
        w_free_found = 1'b0;
        w_hit_idx    = '0;
        w_match      = 1'b0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_idx  = SLOT_W'(i);
                w_free_found = 1'b1;
            end
            if (r_valid[i] && (r_tid[i] == i_lookup_tid)) begin
                w_hit_idx = SLOT_W'(i);
                w_match   = 1'b1;
            end
        end
    end

    assign o_hit         = i_lookup_en && w_match;
    assign o_hit_rw      = r_rw[w_hit_idx];
    assign w_do_alloc    = i_alloc && w_free_found;
    assign o_outstanding = r_count;

    // A slot freed this cycle is still marked valid for allocation; it reopens next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_rw    <= '0;
            r_count <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tid[i] <= '0;
            end
        end else begin
            if (o_hit) begin
                r_valid[w_hit_idx] <= 1'b0;
            end
            if (w_do_alloc) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_tid[w_alloc_idx]   <= i_alloc_tid;
                r_rw[w_alloc_idx]    <= i_alloc_rw;
            end
            if (w_do_alloc && !o_hit) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_alloc && o_hit) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - tags host requests with TIDs, issues them to a FIFO and matches responses
module mem_requester
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int TID_WIDTH       = DEF_TID_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic           clk,
    input  logic           reset,
    mem_requester_if.master bus
);
    localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int IN_TID_LSB = in_tid_lsb(DATA_WIDTH);

    resp_state_t r_state;
    resp_state_t w_state_nxt;

    logic [TID_WIDTH-1:0]  r_next_tid;
    logic [TID_WIDTH-1:0]  r_resp_tid;
    logic                  r_resp_rw;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_err;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_read;
    logic                  w_lookup_en;
    logic                  w_resp_valid;
    logic                  w_hit;
    logic                  w_hit_rw;
    logic [CNT_W-1:0]      w_outstanding;
    logic [TID_WIDTH-1:0]  w_in_tid;
    logic [DATA_WIDTH-1:0] w_in_data;

    assign w_in_tid  = bus.incoming_data[IN_TID_LSB +: TID_WIDTH];
    assign w_in_data = bus.incoming_data[DATA_WIDTH-1:0];

    assign w_req_ready = !bus.full_signal && (w_outstanding < CNT_W'(MAX_OUTSTANDING));
    assign w_accept    = bus.req_valid && w_req_ready && reset;

    mem_req_scoreboard #(
        .TID_WIDTH       (TID_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_alloc       (w_accept),
        .i_alloc_tid   (r_next_tid),
        .i_alloc_rw    (bus.req_rw),
        .i_lookup_en   (w_lookup_en),
        .i_lookup_tid  (w_in_tid),
        .o_hit         (w_hit),
        .o_hit_rw      (w_hit_rw),
        .o_outstanding (w_outstanding)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next_tid <= '0;
        end else if (w_accept) begin
            r_next_tid <= r_next_tid + TID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (!bus.empty_signal) w_state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA: w_state_nxt = w_hit ? ST_HOLD : ST_IDLE;
            ST_HOLD:      if (bus.resp_ready) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_read       = 1'b0;
        w_lookup_en  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE:      w_read       = !bus.empty_signal && reset;
            ST_WAIT_DATA: w_lookup_en  = 1'b1;
            ST_HOLD:      w_resp_valid = 1'b1;
            default:      ;
        endcase
    end

    // Response word arrives the cycle after read_ctr, so capture and miss detection happen in WAIT_DATA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_tid  <= '0;
            r_resp_rw   <= 1'b0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_lookup_en && !w_hit;
            if (w_hit) begin
                r_resp_tid  <= w_in_tid;
                r_resp_rw   <= w_hit_rw;
                r_resp_data <= w_in_data;
            end
        end
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.write_ctr       = w_accept;
    assign bus.outgoing_data   = {r_next_tid, bus.req_rw, bus.req_addr, bus.req_data};
    assign bus.read_ctr        = w_read;
    assign bus.resp_valid      = w_resp_valid;
    assign bus.resp_tid        = r_resp_tid;
    assign bus.resp_rw         = r_resp_rw;
    assign bus.resp_data       = r_resp_data;
    assign bus.outstanding     = w_outstanding;
    assign bus.err_unknown_tid = r_err;

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - randomized and directed self-checking bench for mem_requester
module tb_mem_requester;
    localparam int DW = 32;
    localparam int AW = 31;
    localparam int TW = 8;
    localparam int MO = 4;
    localparam int TID_LSB = DW + AW + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW), .MAX_OUTSTANDING(MO)) bus ();

    mem_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW), .MAX_OUTSTANDING(MO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: live TIDs with their rw, the response FIFO, and the response in flight.
    bit               m_live_rw [bit [TW-1:0]];
    logic [TW-1:0]    issued [$];
    logic [TW+DW-1:0] rfifo [$];
    logic [TW-1:0]    m_tid   = '0;
    logic [TW+DW-1:0] m_word  = '0;
    bit               m_fetch = 1'b0;
    bit               m_hold  = 1'b0;
    bit               m_err   = 1'b0;
    logic [TW-1:0]    m_rtid  = '0;
    bit               m_rrw   = 1'b0;
    logic [DW-1:0]    m_rdata = '0;
    bit               m_acc, m_rd, c_ready;
    logic [TW-1:0]    m_key;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_live_rw.delete();
            issued.delete();
            m_tid   = '0;
            m_fetch = 1'b0;
            m_hold  = 1'b0;
            m_err   = 1'b0;
            m_rtid  = '0;
            m_rrw   = 1'b0;
            m_rdata = '0;
        end else begin
            m_acc = bus.req_valid && !bus.full_signal && (m_live_rw.num() < MO);
            m_rd  = (rfifo.size() != 0) && !m_fetch && !m_hold;
            m_err = 1'b0;
            if (m_fetch) begin
                m_fetch = 1'b0;
                m_key   = m_word[DW +: TW];
                if (m_live_rw.exists(m_key)) begin
                    m_hold  = 1'b1;
                    m_rtid  = m_key;
                    m_rrw   = m_live_rw[m_key];
                    m_rdata = m_word[DW-1:0];
                    m_live_rw.delete(m_key);
                end else begin
                    m_err = 1'b1;
                end
            end else if (m_hold && bus.resp_ready) begin
                m_hold = 1'b0;
            end
            if (m_acc) begin
                m_live_rw[m_tid] = bus.req_rw;
                issued.push_back(m_tid);
                m_tid = m_tid + 1'b1;
            end
            if (m_rd) begin
                m_word  = rfifo.pop_front();
                m_fetch = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            c_ready = !bus.full_signal && (m_live_rw.num() < MO);
            chk("req_ready", bus.req_ready, c_ready);
            chk("write_ctr", bus.write_ctr, bus.req_valid && c_ready);
            if (bus.req_valid && c_ready)
                chk("outgoing_data", bus.outgoing_data, {m_tid, bus.req_rw, bus.req_addr, bus.req_data});
            chk("read_ctr", bus.read_ctr, (rfifo.size() != 0) && !m_fetch && !m_hold);
            chk("resp_valid", bus.resp_valid, m_hold);
            if (m_hold)
                chk("resp_fields", {bus.resp_tid, bus.resp_rw, bus.resp_data}, {m_rtid, m_rrw, m_rdata});
        end else begin
            chk("rst_write_ctr", bus.write_ctr, 1'b0);
            chk("rst_read_ctr", bus.read_ctr, 1'b0);
            chk("rst_resp_valid", bus.resp_valid, 1'b0);
        end
        chk("err_unknown_tid", bus.err_unknown_tid, m_err);
        chk("outstanding", bus.outstanding, m_live_rw.num());
    end

    task automatic cyc();
        @(negedge clk);
        bus.incoming_data = m_word;
        bus.empty_signal  = (rfifo.size() == 0);
    endtask

    task automatic push(input logic [TW-1:0] tid, input logic [DW-1:0] data);
        rfifo.push_back({tid, data});
        bus.empty_signal = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b0;
        bus.req_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [4];
        int k, n_err, n_rv;
        logic [TW-1:0] t;
        order = '{2, 0, 3, 1};
        bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_data = '0;
        bus.full_signal = 1'b0; bus.resp_ready = 1'b1;
        bus.incoming_data = '0; bus.empty_signal = 1'b1;
        repeat (3) cyc();
        #3;
        chk("rst_pin_write", bus.write_ctr, 1'b0);
        chk("rst_pin_regs", {bus.outstanding, bus.resp_valid, bus.resp_tid, bus.resp_rw, bus.resp_data, bus.err_unknown_tid}, '0);
        cyc();
        reset = 1'b1;
        bus.req_valid = 1'b0;

        // single read to 0x10
        cyc();
        bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 31'h10; bus.req_data = '0;
        #3;
        chk("t39_write", bus.write_ctr, 1'b1);
        chk("t39_out", bus.outgoing_data, {8'h00, 1'b1, 31'h10, 32'h0});
        cyc();
        bus.req_valid = 1'b0;
        #3;
        chk("t39_write_off", bus.write_ctr, 1'b0);
        push(8'h00, 32'h7);
        for (int j = 0; j < 20; j++) begin cyc(); #3; if (bus.resp_valid) break; end
        chk("t39_resp", {bus.resp_valid, bus.resp_tid, bus.resp_rw, bus.resp_data}, {1'b1, 8'h00, 1'b1, 32'h7});

        // five back-to-back requests against four slots
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1; bus.req_rw = i[0];
            bus.req_addr = AW'($urandom); bus.req_data = $urandom;
            #3;
            if (i < 4) chk("t40_acc", {bus.write_ctr, bus.outgoing_data[TID_LSB +: TW]}, {1'b1, 8'(i)});
            else       chk("t40_stall", {bus.req_ready, bus.write_ctr, bus.outstanding}, {1'b0, 1'b0, 3'd4});
            cyc();
        end
        push(8'h01, 32'hAB);
        for (int j = 0; j < 20; j++) begin cyc(); #3; if (bus.write_ctr) break; end
        chk("t40_fifth", {bus.write_ctr, bus.outgoing_data[TID_LSB +: TW]}, {1'b1, 8'h04});
        cyc();
        bus.req_valid = 1'b0;

        // out-of-order completion 2,0,3,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1; bus.req_rw = !i[0]; bus.req_addr = AW'(i * 4);
            cyc();
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(order[i]), 32'h100 + order[i]);
        k = 0;
        for (int j = 0; j < 60 && k < 4; j++) begin
            cyc(); #3;
            if (bus.resp_valid) begin
                chk("t41_resp", {bus.resp_tid, bus.resp_rw, bus.resp_data},
                    {8'(order[k]), (order[k] % 2 == 0), 32'h100 + order[k]});
                k++;
            end
        end
        chk("t41_count", k, 4);
        chk("t41_outstanding", bus.outstanding, 3'd0);

        // unknown TID with one live entry
        bus.req_valid = 1'b1; bus.req_rw = 1'b0;
        cyc();
        bus.req_valid = 1'b0;
        push(8'h55, 32'hDEAD);
        n_err = 0; n_rv = 0;
        for (int j = 0; j < 10; j++) begin cyc(); #3; n_err += bus.err_unknown_tid; n_rv += bus.resp_valid; end
        chk("t42_err_pulses", n_err, 1);
        chk("t42_no_resp", n_rv, 0);
        chk("t42_outstanding", bus.outstanding, 3'd1);

        // full blocks writes
        do_reset();
        bus.full_signal = 1'b1; bus.req_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin cyc(); #3; chk("t44_full", {bus.req_ready, bus.write_ctr}, 2'b00); end
        bus.full_signal = 1'b0;
        cyc(); cyc();
        bus.req_valid = 1'b0;
        // hold with resp_ready low, then reset during HOLD
        bus.resp_ready = 1'b0;
        push(8'h00, 32'h11); push(8'h01, 32'h22);
        for (int j = 0; j < 20; j++) begin cyc(); #3; if (bus.resp_valid) break; end
        for (int j = 0; j < 5; j++) begin
            cyc(); #3;
            chk("t44_hold", {bus.resp_valid, bus.read_ctr, bus.empty_signal}, 3'b100);
        end
        reset = 1'b0;
        #1;
        chk("t44_rst_drop", bus.resp_valid, 1'b0);
        cyc();
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        n_err = 0;
        for (int j = 0; j < 10; j++) begin cyc(); #3; n_err += bus.err_unknown_tid; end
        chk("t44_stale_err", n_err, 1);

        // TID wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            bus.req_valid = 1'b1; bus.req_rw = 1'($urandom); bus.req_data = $urandom;
            cyc();
            bus.req_valid = 1'b0;
            push(8'(i), $urandom);
            for (int j = 0; j < 20; j++) begin cyc(); #3; if (bus.resp_valid) break; end
        end
        cyc();
        bus.req_valid = 1'b1;
        #3;
        chk("t43_tid_ff", {bus.write_ctr, bus.outgoing_data[TID_LSB +: TW]}, {1'b1, 8'hFF});
        cyc();
        #3;
        chk("t43_tid_00", {bus.write_ctr, bus.outgoing_data[TID_LSB +: TW]}, {1'b1, 8'h00});
        cyc();
        bus.req_valid = 1'b0;

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid   = ($urandom_range(0, 2) != 0);
            bus.req_rw      = 1'($urandom);
            bus.req_addr    = AW'($urandom);
            bus.req_data    = $urandom;
            bus.full_signal = ($urandom_range(0, 5) == 0);
            bus.resp_ready  = ($urandom_range(0, 3) != 0);
            if (issued.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, issued.size() - 1);
                push(issued[k], $urandom);
                issued.delete(k);
            end else if ($urandom_range(0, 50) == 0) begin
                t = 8'($urandom);
                if (!m_live_rw.exists(t)) push(t, $urandom);
            end
            cyc();
        end
        bus.req_valid = 1'b0; bus.full_signal = 1'b0; bus.resp_ready = 1'b1;
        repeat (50) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
